// File: rtl/ysyx_25040109_mem_arbiter.sv
// ysyx_25040109_mem_arbiter
// Shares one AXI4-style single-beat memory port between the IFU (read only)
// and the LSU (read/write). One transaction is in flight at a time; the
// owner keeps the port from its address phase until its last response.
// Optional feature macro: ARB_RR_EN -- round-robin between the two read
// classes when both request in the same IDLE cycle (writes still win).
//
// Handshake rule: a transfer happens on a rising clock edge where valid and
// ready are both 1. The arbiter never latches payload; in a granted state the
// owner's valid/payload go straight to the slave and the slave's ready (or
// response valid) goes straight back to the owner. Everything not owned sees
// ready=0 / valid=0.
module ysyx_25040109_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read port
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic                ifu_rlast,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  // LSU read port
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic                lsu_rlast,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  // LSU write port
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic                lsu_wlast,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  // Slave port
  output logic                mem_arvalid,
  input  logic                mem_arready,
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic [7:0]          mem_arlen,
  output logic [2:0]          mem_arsize,
  output logic [1:0]          mem_arburst,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic                mem_rlast,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_rresp,
  output logic                mem_awvalid,
  input  logic                mem_awready,
  output logic [ADDR_W-1:0]   mem_awaddr,
  output logic [7:0]          mem_awlen,
  output logic [2:0]          mem_awsize,
  output logic [1:0]          mem_awburst,
  output logic                mem_wvalid,
  input  logic                mem_wready,
  output logic                mem_wlast,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_bvalid,
  output logic                mem_bready,
  input  logic [1:0]          mem_bresp,
  // Current owner; equals the FSM state encoding
  output logic [1:0]          grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IFU_R = 2'b01,
    ST_LSU_R = 2'b10,
    ST_LSU_W = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic r_done;
  logic b_done;

  assign r_done = mem_rvalid & mem_rready & mem_rlast;
  assign b_done = mem_bvalid & mem_bready;

`ifdef ARB_RR_EN
  // 0 = IFU read was granted last, 1 = LSU read was granted last
  logic last_grant;

  // Remember which read class won most recently so a tie goes to the other one
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= 1'b0;
    end else if (state == ST_IDLE && state_nxt == ST_IFU_R) begin
      last_grant <= 1'b0;
    end else if (state == ST_IDLE && state_nxt == ST_LSU_R) begin
      last_grant <= 1'b1;
    end
  end
`endif

  // State register; reset abandons any in-flight transaction
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration in IDLE, release on the owner's final response
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (lsu_awvalid) begin
          state_nxt = ST_LSU_W;
        end else if (lsu_arvalid && ifu_arvalid) begin
`ifdef ARB_RR_EN
          state_nxt = last_grant ? ST_IFU_R : ST_LSU_R;
`else
          state_nxt = ST_LSU_R;
`endif
        end else if (lsu_arvalid) begin
          state_nxt = ST_LSU_R;
        end else if (ifu_arvalid) begin
          state_nxt = ST_IFU_R;
        end
      end
      ST_IFU_R, ST_LSU_R: begin
        if (r_done) state_nxt = ST_IDLE;
      end
      ST_LSU_W: begin
        if (b_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake routing: only the owner is connected to the slave
  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    mem_arvalid = 1'b0;
    mem_rready  = 1'b0;
    mem_awvalid = 1'b0;
    mem_wvalid  = 1'b0;
    mem_bready  = 1'b0;
    case (state)
      ST_IFU_R: begin
        mem_arvalid = ifu_arvalid;
        ifu_arready = mem_arready;
        ifu_rvalid  = mem_rvalid;
        mem_rready  = ifu_rready;
      end
      ST_LSU_R: begin
        mem_arvalid = lsu_arvalid;
        lsu_arready = mem_arready;
        lsu_rvalid  = mem_rvalid;
        mem_rready  = lsu_rready;
      end
      ST_LSU_W: begin
        mem_awvalid = lsu_awvalid;
        lsu_awready = mem_awready;
        mem_wvalid  = lsu_wvalid;
        lsu_wready  = mem_wready;
        lsu_bvalid  = mem_bvalid;
        mem_bready  = lsu_bready;
      end
      default: ;
    endcase
  end

  // Payload paths: qualified by the valids above, so no gating needed
  assign mem_araddr  = (state == ST_LSU_R) ? lsu_araddr : ifu_araddr;
  assign mem_awaddr  = lsu_awaddr;
  assign mem_wdata   = lsu_wdata;
  assign mem_wstrb   = lsu_wstrb;
  assign mem_wlast   = lsu_wlast;
  assign ifu_rdata   = mem_rdata;
  assign ifu_rresp   = mem_rresp;
  assign ifu_rlast   = mem_rlast;
  assign lsu_rdata   = mem_rdata;
  assign lsu_rresp   = mem_rresp;
  assign lsu_rlast   = mem_rlast;
  assign lsu_bresp   = mem_bresp;

  // Fixed single-beat, word-sized, incrementing bursts
  assign mem_arlen   = 8'd0;
  assign mem_arsize  = 3'b010;
  assign mem_arburst = 2'b01;
  assign mem_awlen   = 8'd0;
  assign mem_awsize  = 3'b010;
  assign mem_awburst = 2'b01;

  assign grant = state;

endmodule
